// File: rtl/aq_ifu_ras.sv
// Return address stack for the IFU: circular array of predicted return
// targets, pushed on link instructions, popped on returns, cleared on flush.
module aq_ifu_ras #(
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                         cpuclk,
    input  logic                         cpurst_b,
    input  logic                         pred_link_vld0,
    input  logic                         pred_ret_vld0,
    input  logic [39:0]                  ipack_pred_pc,
    input  logic                         ifu_ras_upd_en,
    input  logic                         rtu_ifu_flush,
    output logic [39:0]                  ras_pred_ret_pc,
    output logic                         ras_pred_ret_vld,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [39:0]   r_entry [RAS_DEPTH];
    logic [PW-1:0] r_tos_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_replace;
    logic          w_cnt_zero;
    logic          w_cnt_full;
    logic [39:0]   w_push_val;
    logic [PW-1:0] w_nxt_ptr;
    logic [CW-1:0] w_nxt_cnt;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;

    assign w_push     = ifu_ras_upd_en &  pred_link_vld0 & ~pred_ret_vld0;
    assign w_pop      = ifu_ras_upd_en &  pred_ret_vld0  & ~pred_link_vld0;
    assign w_replace  = ifu_ras_upd_en &  pred_link_vld0 &  pred_ret_vld0;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_full = (r_cnt == CNT_FULL);
    assign w_push_val = ipack_pred_pc + 40'd4;

    // Next pointer/count and entry write selection; flush wins over all ops,
    // and a replace on an empty stack is treated as a push.
    always_comb begin
        w_nxt_ptr = r_tos_ptr;
        w_nxt_cnt = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_tos_ptr;
        if (rtu_ifu_flush) begin
            w_nxt_ptr = '0;
            w_nxt_cnt = '0;
        end else if (w_push || (w_replace && w_cnt_zero)) begin
            w_nxt_ptr = r_tos_ptr + PTR_ONE;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_tos_ptr + PTR_ONE;
            w_nxt_cnt = w_cnt_full ? r_cnt : (r_cnt + CNT_ONE);
        end else if (w_replace) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_tos_ptr;
        end else if (w_pop && !w_cnt_zero) begin
            w_nxt_ptr = r_tos_ptr - PTR_ONE;
            w_nxt_cnt = r_cnt - CNT_ONE;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_tos_ptr <= '0;
            r_cnt     <= '0;
        end else begin
            r_tos_ptr <= w_nxt_ptr;
            r_cnt     <= w_nxt_cnt;
        end
    end

    // Stack entries; flush leaves contents in place, reset clears them.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (w_wr_en && !rtu_ifu_flush) begin
            r_entry[w_wr_idx] <= w_push_val;
        end
    end

    assign ras_pred_ret_pc  = w_cnt_zero ? '0 : r_entry[r_tos_ptr];
    assign ras_pred_ret_vld = !w_cnt_zero;
    assign ras_empty        = w_cnt_zero;
    assign ras_full         = w_cnt_full;
    assign ras_cnt          = r_cnt;

endmodule

// File: tb/tb_aq_ifu_ras.sv
// Bench for aq_ifu_ras: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_aq_ifu_ras;

    localparam int DEPTH = 8;

    logic        cpuclk;
    logic        cpurst_b;
    logic        pred_link_vld0;
    logic        pred_ret_vld0;
    logic [39:0] ipack_pred_pc;
    logic        ifu_ras_upd_en;
    logic        rtu_ifu_flush;
    logic [39:0] ras_pred_ret_pc;
    logic        ras_pred_ret_vld;
    logic        ras_empty;
    logic        ras_full;
    logic [3:0]  ras_cnt;

    int checks   = 0;
    int failures = 0;

    logic [39:0] mq [$];

    aq_ifu_ras #(.RAS_DEPTH(DEPTH)) u_dut (
        .cpuclk           (cpuclk),
        .cpurst_b         (cpurst_b),
        .pred_link_vld0   (pred_link_vld0),
        .pred_ret_vld0    (pred_ret_vld0),
        .ipack_pred_pc    (ipack_pred_pc),
        .ifu_ras_upd_en   (ifu_ras_upd_en),
        .rtu_ifu_flush    (rtu_ifu_flush),
        .ras_pred_ret_pc  (ras_pred_ret_pc),
        .ras_pred_ret_vld (ras_pred_ret_vld),
        .ras_empty        (ras_empty),
        .ras_full         (ras_full),
        .ras_cnt          (ras_cnt)
    );

    initial begin
        cpuclk = 1'b0;
        forever #5 cpuclk = ~cpuclk;
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the stack is the list of most recent live pushes.
    always @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b || rtu_ifu_flush) begin
            mq.delete();
        end else if (ifu_ras_upd_en) begin
            if (pred_link_vld0 && (!pred_ret_vld0 || mq.size() == 0)) begin
                mq.push_back(ipack_pred_pc + 40'd4);
                if (mq.size() > DEPTH) void'(mq.pop_front());
            end else if (pred_link_vld0 && pred_ret_vld0) begin
                void'(mq.pop_back());
                mq.push_back(ipack_pred_pc + 40'd4);
            end else if (pred_ret_vld0 && mq.size() > 0) begin
                void'(mq.pop_back());
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge cpuclk) begin
        int n;
        n = mq.size();
        chk("m_cnt", 40'(ras_cnt), 40'(n));
        chk("m_pc", ras_pred_ret_pc, (n == 0) ? 40'h0 : mq[n-1]);
        chk("m_vld", 40'(ras_pred_ret_vld), 40'(n != 0));
        chk("m_empty", 40'(ras_empty), 40'(n == 0));
        chk("m_full", 40'(ras_full), 40'(n == DEPTH));
    end

    task automatic step(input logic link, input logic ret, input logic [39:0] pc,
                        input logic upd, input logic flush);
        pred_link_vld0 = link;
        pred_ret_vld0  = ret;
        ipack_pred_pc  = pc;
        ifu_ras_upd_en = upd;
        rtu_ifu_flush  = flush;
        @(posedge cpuclk);
        #1;
        pred_link_vld0 = 1'b0;
        pred_ret_vld0  = 1'b0;
        ifu_ras_upd_en = 1'b0;
        rtu_ifu_flush  = 1'b0;
    endtask

    task automatic push(input logic [39:0] pc);
        step(1'b1, 1'b0, pc, 1'b1, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b1, 40'h0, 1'b1, 1'b0);
    endtask

    initial begin
        cpurst_b       = 1'b0;
        pred_link_vld0 = 1'b0;
        pred_ret_vld0  = 1'b0;
        ipack_pred_pc  = '0;
        ifu_ras_upd_en = 1'b0;
        rtu_ifu_flush  = 1'b0;
        #2;
        chk("rst_cnt", 40'(ras_cnt), 40'd0);
        chk("rst_empty", 40'(ras_empty), 40'd1);
        chk("rst_pc", ras_pred_ret_pc, 40'h0);
        @(negedge cpuclk);
        @(negedge cpuclk);
        cpurst_b = 1'b1;
        @(posedge cpuclk);
        #1;

        // push then pop
        push(40'h00_0000_1000);
        chk("pp_top", ras_pred_ret_pc, 40'h00_0000_1004);
        chk("pp_vld", 40'(ras_pred_ret_vld), 40'd1);
        pop();
        chk("pp_cnt", 40'(ras_cnt), 40'd0);
        chk("pp_vld0", 40'(ras_pred_ret_vld), 40'd0);

        // overflow: nine pushes into eight entries
        for (int i = 1; i <= 9; i++) push(40'(i * 256));
        chk("ov_cnt", 40'(ras_cnt), 40'd8);
        chk("ov_full", 40'(ras_full), 40'd1);
        for (int k = 0; k < 8; k++) begin
            chk("ov_top", ras_pred_ret_pc, 40'((9 - k) * 256 + 4));
            pop();
        end
        chk("ov_cnt0", 40'(ras_cnt), 40'd0);
        pop();
        chk("ov_under", 40'(ras_cnt), 40'd0);
        chk("ov_empty", 40'(ras_empty), 40'd1);

        // replace on a non-empty and on an empty stack
        push(40'h2000);
        step(1'b1, 1'b1, 40'h3000, 1'b1, 1'b0);
        chk("rp_cnt", 40'(ras_cnt), 40'd1);
        chk("rp_top", ras_pred_ret_pc, 40'h3004);
        pop();
        step(1'b1, 1'b1, 40'h5000, 1'b1, 1'b0);
        chk("rp0_cnt", 40'(ras_cnt), 40'd1);
        chk("rp0_top", ras_pred_ret_pc, 40'h5004);
        pop();

        // gating and flush
        push(40'hA000);
        push(40'hB000);
        push(40'hC000);
        step(1'b0, 1'b1, 40'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 40'hD000, 1'b0, 1'b0);
        chk("gt_cnt", 40'(ras_cnt), 40'd3);
        chk("gt_top", ras_pred_ret_pc, 40'hC004);
        step(1'b1, 1'b0, 40'hD000, 1'b1, 1'b1);
        chk("fl_cnt", 40'(ras_cnt), 40'd0);
        chk("fl_empty", 40'(ras_empty), 40'd1);
        pop();
        push(40'hE000);
        chk("fl_push", ras_pred_ret_pc, 40'hE004);

        // 40-bit wrap
        push(40'hFF_FFFF_FFFC);
        chk("wr_top", ras_pred_ret_pc, 40'h0);
        chk("wr_vld", 40'(ras_pred_ret_vld), 40'd1);
        chk("wr_cnt", 40'(ras_cnt), 40'd2);

        // mixed sequence covered by the model
        for (int i = 0; i < 40; i++) begin
            case (i % 5)
                0, 1:    push(40'(i * 40'h111 + 40'h10));
                2:       pop();
                3:       step(1'b1, 1'b1, 40'(i * 40'h333), 1'b1, 1'b0);
                default: step(1'b0, 1'b1, 40'h0, (i % 10) != 4, 1'b0);
            endcase
        end

        // asynchronous reset mid-cycle at cnt=5
        step(1'b0, 1'b0, 40'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) push(40'(40'h6000 + i * 16));
        chk("ar_pre", 40'(ras_cnt), 40'd5);
        @(negedge cpuclk);
        #2;
        cpurst_b = 1'b0;
        #1;
        chk("ar_cnt", 40'(ras_cnt), 40'd0);
        chk("ar_pc", ras_pred_ret_pc, 40'h0);
        chk("ar_vld", 40'(ras_pred_ret_vld), 40'd0);
        chk("ar_empty", 40'(ras_empty), 40'd1);
        chk("ar_full", 40'(ras_full), 40'd0);
        @(negedge cpuclk);
        @(negedge cpuclk);
        cpurst_b = 1'b1;
        @(posedge cpuclk);
        #1;
        push(40'h7000);
        chk("ar_push", ras_pred_ret_pc, 40'h7004);
        chk("ar_cnt1", 40'(ras_cnt), 40'd1);
        pop();
        chk("ar_nores", ras_pred_ret_pc, 40'h0);
        chk("ar_empty2", 40'(ras_empty), 40'd1);

        @(negedge cpuclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
